perceptron_trainer: RTL and testbench

PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

---
 rtl/npu_pkg.sv | 14 +
 rtl/sat_add.sv | 32 +++
 rtl/width.svh | 10 +
 rtl/perceptron_trainer.sv | 133 +++++++++++++
 tb/tb_perceptron_trainer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_pkg.sv
// Shared NPU types: trainer FSM state encoding and signed saturation bounds.
package npu_pkg;

   typedef enum logic [1:0] {StIdle, StUpdate, StBias, StDone} trainer_state_t;

   function automatic logic signed [63:0] sat_max(input int unsigned width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_min(input int unsigned width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage

// File: rtl/sat_add.sv
// Adds a wide signed delta to a narrow signed value and clamps the result to the narrow range.
`include "width.svh"

module sat_add
   import npu_pkg::*;
#(
   parameter int unsigned ACC_WIDTH  = `ACC_WIDTH,
   parameter int unsigned DATA_WIDTH = `DATA_WIDTH
) (
   input  logic signed [DATA_WIDTH-1:0] a_i,
   input  logic signed [ACC_WIDTH-1:0]  delta_i,
   output logic signed [DATA_WIDTH-1:0] sum_o
);

   localparam logic signed [ACC_WIDTH:0] SatMax = (ACC_WIDTH + 1)'(sat_max(DATA_WIDTH));
   localparam logic signed [ACC_WIDTH:0] SatMin = (ACC_WIDTH + 1)'(sat_min(DATA_WIDTH));

   // One extra bit so the raw sum can never wrap before clamping.
   logic signed [ACC_WIDTH:0] full;

   always_comb begin
      full = (ACC_WIDTH + 1)'(a_i) + (ACC_WIDTH + 1)'(delta_i);
      if (full > SatMax) begin
         sum_o = DATA_WIDTH'(SatMax);
      end else if (full < SatMin) begin
         sum_o = DATA_WIDTH'(SatMin);
      end else begin
         sum_o = DATA_WIDTH'(full);
      end
   end

endmodule

// File: rtl/width.svh
// Default datapath widths shared by the NPU blocks; override by defining the macros first.
`ifndef WIDTH_SVH
`define WIDTH_SVH
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif
`endif

// File: rtl/perceptron_trainer.sv
// Delta-rule trainer for a ReLU perceptron: one weight updated per cycle, then the bias,
// with saturating arithmetic and a learning rate of 2^-LR_SHIFT.
`include "width.svh"

module perceptron_trainer
   import npu_pkg::*;
#(
   parameter int unsigned N          = 4,
   parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
   parameter int unsigned ACC_WIDTH  = `ACC_WIDTH,
   parameter int unsigned LR_SHIFT   = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic signed [N-1:0][DATA_WIDTH-1:0] x,
   input  logic signed [DATA_WIDTH-1:0]        y,
   input  logic signed [DATA_WIDTH-1:0]        target,
   input  logic                                load_en,
   input  logic signed [N-1:0][DATA_WIDTH-1:0] load_w,
   input  logic signed [DATA_WIDTH-1:0]        load_b,
   output logic signed [N-1:0][DATA_WIDTH-1:0] w,
   output logic signed [DATA_WIDTH-1:0]        b,
   output logic                                busy,
   output logic                                done
);

   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

   trainer_state_t state_q, state_d;

   logic [IdxW-1:0]                  idx_q;
   logic [N-1:0][DATA_WIDTH-1:0]     w_q;
   logic [N-1:0][DATA_WIDTH-1:0]     x_q;
   logic signed [DATA_WIDTH-1:0]     b_q;
   logic signed [DATA_WIDTH:0]       err_q;
   logic signed [DATA_WIDTH:0]       err_in;
   logic signed [ACC_WIDTH-1:0]      w_prod;
   logic signed [ACC_WIDTH-1:0]      w_delta;
   logic signed [ACC_WIDTH-1:0]      b_delta;
   logic signed [DATA_WIDTH-1:0]     w_upd;
   logic signed [DATA_WIDTH-1:0]     b_upd;
   logic                             accept;
   logic                             load;
   logic                             skip;
   logic                             last_idx;

   assign accept   = in_valid && in_ready;
   assign load     = load_en && (state_q == StIdle);
   assign err_in   = (DATA_WIDTH + 1)'(target) - (DATA_WIDTH + 1)'(y);
   // ReLU gradient is zero for y <= 0, and a zero error changes nothing.
   assign skip     = y[DATA_WIDTH-1] || (y == '0) || (err_in == '0);
   assign last_idx = (idx_q == IdxW'(N - 1));

   assign w_prod  = ACC_WIDTH'(err_q) * ACC_WIDTH'($signed(x_q[idx_q]));
   assign w_delta = w_prod >>> LR_SHIFT;
   assign b_delta = ACC_WIDTH'(err_q) >>> LR_SHIFT;

   sat_add #(
      .ACC_WIDTH  (ACC_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_sat_w (
      .a_i     ($signed(w_q[idx_q])),
      .delta_i (w_delta),
      .sum_o   (w_upd)
   );

   sat_add #(
      .ACC_WIDTH  (ACC_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_sat_b (
      .a_i     (b_q),
      .delta_i (b_delta),
      .sum_o   (b_upd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (accept) state_d = skip ? StDone : StUpdate;
         StUpdate: if (last_idx) state_d = StBias;
         StBias:   state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready = (state_q == StIdle) && !load_en;
      busy     = (state_q != StIdle);
      done     = (state_q == StDone);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         w_q   <= '0;
         b_q   <= '0;
         x_q   <= '0;
         err_q <= '0;
      end else begin
         if (load) begin
            w_q <= load_w;
            b_q <= load_b;
         end
         if (accept) begin
            x_q   <= x;
            err_q <= err_in;
            idx_q <= '0;
         end
         if (state_q == StUpdate) begin
            w_q[idx_q] <= w_upd;
            idx_q      <= last_idx ? '0 : idx_q + 1'b1;
         end
         if (state_q == StBias) begin
            b_q <= b_upd;
         end
      end
   end

   assign w = w_q;
   assign b = b_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench for perceptron_trainer at N=4, DATA_WIDTH=8, LR_SHIFT=2.
module tb_perceptron_trainer;

   typedef int vec_t[4];
   typedef struct {
      int w[4];
      int b;
      int lat;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [3:0][7:0]    x = '0;
   logic [7:0]         y = '0;
   logic [7:0]         target = '0;
   logic               load_en = 1'b0;
   logic [3:0][7:0]    load_w = '0;
   logic [7:0]         load_b = '0;
   logic [3:0][7:0]    w;
   logic [7:0]         b;
   logic               busy;
   logic               done;

   int checks = 0;
   int passed = 0;
   int mw[4];
   int mb;
   exp_t exp_q[$];

   perceptron_trainer #(
      .N          (4),
      .DATA_WIDTH (8),
      .ACC_WIDTH  (32),
      .LR_SHIFT   (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x        (x),
      .y        (y),
      .target   (target),
      .load_en  (load_en),
      .load_w   (load_w),
      .load_b   (load_b),
      .w        (w),
      .b        (b),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   function automatic int clamp8(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   // Reference delta rule with ReLU gradient; returns expected done latency.
   function automatic int model_apply(input vec_t xv, input int yv, input int tv);
      int err;
      err = tv - yv;
      if (yv <= 0 || err == 0) return 1;
      for (int i = 0; i < 4; i++) mw[i] = clamp8(mw[i] + ((err * xv[i]) >>> 2));
      mb = clamp8(mb + (err >>> 2));
      return 6;
   endfunction

   function automatic exp_t snapshot(input int lat);
      exp_t e;
      for (int i = 0; i < 4; i++) e.w[i] = mw[i];
      e.b = mb;
      e.lat = lat;
      return e;
   endfunction

   task automatic do_load(input vec_t wv, input int bv);
      @(negedge clk);
      for (int i = 0; i < 4; i++) load_w[i] = 8'(wv[i]);
      load_b  = 8'(bv);
      load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
      for (int i = 0; i < 4; i++) mw[i] = wv[i];
      mb = bv;
   endtask

   // Drives one sample, scrambles inputs right after acceptance, returns cycles until done.
   task automatic run_sample(input vec_t xv, input int yv, input int tv, output int lat);
      @(negedge clk);
      for (int i = 0; i < 4; i++) x[i] = 8'(xv[i]);
      y        = 8'(yv);
      target   = 8'(tv);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x        = 32'hA55A_C33C;
      y        = 8'd99;
      target   = 8'hCE;
      lat      = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (done) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++; if (w !== '0) $display("FAIL reset_w got %h want 0", w); else passed++;
      checks++; if (b !== '0) $display("FAIL reset_b got %h want 0", b); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready);
      else passed++;
      mw = '{0, 0, 0, 0};
      mb = 0;
   endtask

   task automatic test_load;
      logic [3:0][7:0] ew;
      @(negedge clk);
      load_w  = {8'd4, 8'd3, 8'd2, 8'd1};
      load_b  = 8'd5;
      load_en = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) $display("FAIL load_ready got %b want 0", in_ready);
      else passed++;
      @(negedge clk);
      load_en = 1'b0;
      mw = '{1, 2, 3, 4};
      mb = 5;
      for (int i = 0; i < 4; i++) ew[i] = 8'(mw[i]);
      checks++; if (w !== ew) $display("FAIL load_w got %h want %h", w, ew); else passed++;
      checks++; if (b !== 8'd5) $display("FAIL load_b got %h want 05", b); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL load_busy got %b want 0", busy); else passed++;
   endtask

   task automatic check_sample(input string name, input vec_t xv, input int yv, input int tv);
      int lat;
      exp_t e;
      logic [3:0][7:0] ew;
      exp_q.push_back(snapshot(model_apply(xv, yv, tv)));
      run_sample(xv, yv, tv, lat);
      e = exp_q.pop_front();
      for (int i = 0; i < 4; i++) ew[i] = 8'(e.w[i]);
      checks++; if (w !== ew) $display("FAIL %s_w got %h want %h", name, w, ew); else passed++;
      checks++; if (b !== 8'(e.b)) $display("FAIL %s_b got %h want %h", name, b, 8'(e.b));
      else passed++;
      checks++; if (lat !== e.lat) $display("FAIL %s_latency got %0d want %0d", name, lat, e.lat);
      else passed++;
   endtask

   task automatic test_update;
      logic [3:0][7:0] lit;
      check_sample("update", '{4, 8, -4, 0}, 10, 14);
      lit = {8'd4, 8'hFF, 8'd10, 8'd5};
      checks++; if (w !== lit) $display("FAIL update_literal got %h want %h", w, lit);
      else passed++;
   endtask

   task automatic test_skip;
      check_sample("skip_y0", '{3, 3, 3, 3}, 0, 20);
      check_sample("skip_yneg", '{1, 2, 3, 4}, -3, 5);
      check_sample("skip_err0", '{5, 5, 5, 5}, 7, 7);
   endtask

   task automatic test_saturation;
      do_load('{120, 0, 0, 0}, 0);
      check_sample("sat_hi", '{100, 0, 0, 0}, 10, 30);
      checks++; if (w[0] !== 8'd127) $display("FAIL sat_hi_w0 got %0d want 127", $signed(w[0]));
      else passed++;
      do_load('{-120, 0, 0, 0}, 0);
      check_sample("sat_lo", '{100, 0, 0, 0}, 10, -10);
      checks++; if (w[0] !== 8'h80) $display("FAIL sat_lo_w0 got %0d want -128", $signed(w[0]));
      else passed++;
   endtask

   task automatic test_reset_mid;
      int pulses = 0;
      do_load('{1, 2, 3, 4}, 5);
      @(negedge clk);
      x        = {8'd0, 8'hFC, 8'd8, 8'd4};
      y        = 8'd10;
      target   = 8'd14;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++; if (w !== '0) $display("FAIL midrst_w got %h want 0", w); else passed++;
      checks++; if (b !== '0) $display("FAIL midrst_b got %h want 0", b); else passed++;
      @(negedge clk);
      rst = 1'b0;
      mw = '{0, 0, 0, 0};
      mb = 0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", in_ready);
      else passed++;
      for (int c = 0; c < 8; c++) begin
         if (done) pulses++;
         @(negedge clk);
      end
      checks++; if (pulses !== 0) $display("FAIL midrst_done got %0d pulses want 0", pulses);
      else passed++;
   endtask

   task automatic test_back_to_back;
      vec_t xa = '{4, 8, -4, 0};
      vec_t xb = '{2, -2, 1, 3};
      int acc = 0;
      int dones = 0;
      int viol = 0;
      exp_t e;
      logic [3:0][7:0] ew;
      exp_q.push_back(snapshot(model_apply(xa, 10, 14)));
      exp_q.push_back(snapshot(model_apply(xb, 5, -3)));
      @(negedge clk);
      for (int i = 0; i < 4; i++) x[i] = 8'(xa[i]);
      y        = 8'd10;
      target   = 8'd14;
      in_valid = 1'b1;
      for (int c = 0; c < 60 && dones < 2; c++) begin
         if (done) dones++;
         if (busy && in_ready) viol++;
         if (in_ready && in_valid) begin
            acc++;
            @(posedge clk);
            #1;
            if (acc == 1) begin
               for (int i = 0; i < 4; i++) x[i] = 8'(xb[i]);
               y      = 8'd5;
               target = 8'hFD;
            end else begin
               in_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      void'(exp_q.pop_front());
      e = exp_q.pop_front();
      for (int i = 0; i < 4; i++) ew[i] = 8'(e.w[i]);
      checks++; if (acc !== 2) $display("FAIL b2b_accepts got %0d want 2", acc); else passed++;
      checks++; if (dones !== 2) $display("FAIL b2b_dones got %0d want 2", dones); else passed++;
      checks++; if (viol !== 0) $display("FAIL b2b_ready_busy got %0d want 0", viol); else passed++;
      checks++; if (w !== ew) $display("FAIL b2b_w got %h want %h", w, ew); else passed++;
      checks++; if (b !== 8'(e.b)) $display("FAIL b2b_b got %h want %h", b, 8'(e.b));
      else passed++;
   endtask

   initial begin
      test_reset();
      test_load();
      test_update();
      test_skip();
      test_saturation();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
